// File: rtl/fetch_pkg.sv
// Shared widths, opcode constant and FSM state type for the instruction fetch slice.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_OFF_W   = 8;

    // Major opcode of the PC-relative branch family (top nibble of an instruction).
    localparam logic [3:0] OP_BR = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    function automatic logic is_branch_op(input logic [3:0] opcode);
        return opcode == OP_BR;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with occupancy count; head data is the stored entry at the read pointer.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pop only when head_vld & pop_rdy; pushes into a full FIFO are dropped (callers check count).
module fetch_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop_rdy & head_vld;
    assign do_push  = push_vld & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage array; contents are don't-care until covered by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues single outstanding memory reads, predecodes branches, buffers {PC, instr}.
// Latency: REQ->GNT->RVALID, at best one instruction every 2 cycles; head visible the cycle after RVALID.
// Backpressure: INSTR_READY low fills the fetch buffer, then fetch parks in IDLE; optional perf counters under FETCH_PERF_CNT_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_W       = DEF_ADDR_W,
    parameter int               INSTR_W      = DEF_INSTR_W,
    parameter int               OFF_W        = DEF_OFF_W,
    parameter int               FIFO_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    output logic [ADDR_W-1:0]  PC,
    output logic               BRANCH,
    output logic [OFF_W-1:0]   OFFSET,
    input  logic [ADDR_W-1:0]  NEXT_PC,
    output logic               MEM_REQ,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    input  logic               MEM_GNT,
    input  logic               MEM_RVALID,
    input  logic [INSTR_W-1:0] MEM_RDATA,
    output logic               INSTR_VALID,
    input  logic               INSTR_READY,
    output logic [INSTR_W-1:0] INSTR,
    output logic [ADDR_W-1:0]  INSTR_PC,
    output logic [15:0]        FETCH_CNT,
    output logic [15:0]        BRANCH_CNT
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              rsp_accept;
    logic              is_br;
    logic              fifo_has_room;
    logic              room_after_push;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // A response only counts while waiting for it; anything else is a leftover from before a reset.
    assign rsp_accept      = RESET_N & (state_q == WAIT) & MEM_RVALID;
    assign is_br           = is_branch_op(MEM_RDATA[INSTR_W-1 -: 4]);
    assign fifo_has_room   = (fifo_count < CNT_W'(FIFO_DEPTH));
    // Room is guaranteed at push time, so after the push there is space unless this fills the last slot without a pop.
    assign room_after_push = (fifo_count < CNT_W'(FIFO_DEPTH - 1)) | (INSTR_VALID & INSTR_READY);

    assign PC       = pc_q;
    assign MEM_ADDR = pc_q;

    // Next-state, request and branch predecode; the branch offset closes the loop through progCntr combinationally.
    always_comb begin
        state_d = state_q;
        MEM_REQ = 1'b0;
        BRANCH  = 1'b0;
        OFFSET  = '0;
        case (state_q)
            IDLE: begin
                if (fifo_has_room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                MEM_REQ = 1'b1;
                if (MEM_GNT) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (MEM_RVALID) begin
                    state_d = room_after_push ? REQ : IDLE;
                    if (is_br) begin
                        BRANCH = 1'b1;
                        OFFSET = MEM_RDATA[OFF_W-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Nothing leaves the block while reset is held, whatever state the register is in.
        if (!RESET_N) begin
            MEM_REQ = 1'b0;
            BRANCH  = 1'b0;
            OFFSET  = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC advances to progCntr's result on the same edge the fetched instruction is buffered.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pc_q <= RESET_VECTOR;
        end else if (rsp_accept) begin
            pc_q <= NEXT_PC;
        end
    end

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = MEM_RDATA;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .push_vld (rsp_accept),
        .push_dat (push_entry),
        .pop_rdy  (INSTR_READY),
        .head_vld (INSTR_VALID),
        .head_dat (head_entry),
        .count    (fifo_count)
    );

    assign INSTR    = head_entry.instr;
    assign INSTR_PC = head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] branch_cnt_q;

    // Saturating perf counters: accepted fetches and predecoded branches.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            fetch_cnt_q  <= '0;
            branch_cnt_q <= '0;
        end else begin
            if (rsp_accept && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (BRANCH && (branch_cnt_q != 16'hFFFF)) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
        end
    end

    assign FETCH_CNT  = fetch_cnt_q;
    assign BRANCH_CNT = branch_cnt_q;
`else
    assign FETCH_CNT  = 16'h0;
    assign BRANCH_CNT = 16'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] PC;
    logic        BRANCH;
    logic [7:0]  OFFSET;
    logic [15:0] NEXT_PC;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_GNT;
    logic        MEM_RVALID;
    logic [15:0] MEM_RDATA;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [15:0] INSTR;
    logic [15:0] INSTR_PC;
    logic [15:0] FETCH_CNT;
    logic [15:0] BRANCH_CNT;

    always #5 CLK = ~CLK;

    // progCntr reference: PC+1, or PC+sext(OFFSET) when BRANCH.
    assign NEXT_PC = BRANCH ? (PC + {{8{OFFSET[7]}}, OFFSET}) : (PC + 16'd1);

    instr_fetch_unit dut (
        .CLK(CLK), .RESET_N(RESET_N), .PC(PC), .BRANCH(BRANCH), .OFFSET(OFFSET),
        .NEXT_PC(NEXT_PC), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(MEM_GNT),
        .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
        .FETCH_CNT(FETCH_CNT), .BRANCH_CNT(BRANCH_CNT)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    typedef struct {
        logic [15:0] data;
        logic        exp_br;
        logic [7:0]  exp_off;
        int          delta;
    } br_vec_t;

    int     vec_cnt = 0;
    int     err_cnt = 0;
    entry_t exp_q[$];

    // Memory responder controls and observations.
    logic        gnt_en = 1'b1;
    logic        hold_rsp = 1'b0;
    logic        force_rvalid = 1'b0;
    logic        ovr_en = 1'b0;
    logic        ovr_any = 1'b0;
    logic [15:0] ovr_addr = '0;
    logic [15:0] ovr_data = '0;
    logic        pend = 1'b0;
    logic        pend_stale = 1'b0;
    logic [15:0] pend_addr = '0;
    int          rsp_cnt = 0;
    logic        rsp_branch = 1'b0;
    logic [7:0]  rsp_offset = '0;
    logic [15:0] rsp_addr = '0;
    int          pop_cnt = 0;
    int          tb_fetch = 0;
    int          tb_br = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Memory model plus scoreboard, all evaluated on the falling edge.
    initial begin
        logic [15:0] data;
        logic        stale;
        entry_t      e;
        MEM_GNT    = 1'b0;
        MEM_RVALID = 1'b0;
        MEM_RDATA  = '0;
        forever begin
            @(negedge CLK);
            if (RESET_N) begin
                check("instr_valid", 32'(INSTR_VALID), 32'(exp_q.size() != 0));
`ifdef FETCH_PERF_CNT_EN
                check("fetch_cnt", 32'(FETCH_CNT), 32'(tb_fetch));
                check("branch_cnt", 32'(BRANCH_CNT), 32'(tb_br));
`else
                check("fetch_cnt", 32'(FETCH_CNT), 32'h0);
                check("branch_cnt", 32'(BRANCH_CNT), 32'h0);
`endif
                if (INSTR_VALID && INSTR_READY) begin
                    if (exp_q.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL pop: DUT popped pc %h instr %h, expected nothing", INSTR_PC, INSTR);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_pc", 32'(INSTR_PC), 32'(e.pc));
                        check("instr", 32'(INSTR), 32'(e.instr));
                        pop_cnt++;
                    end
                end
            end else begin
                exp_q.delete();
                tb_fetch = 0;
                tb_br = 0;
            end

            MEM_RVALID = 1'b0;
            MEM_GNT    = 1'b0;
            if (force_rvalid) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA  = 16'hC0FE;
            end else if (pend && !hold_rsp) begin
                stale = pend_stale | ~RESET_N;
                data  = 16'h1000 + pend_addr;
                if (ovr_en && (ovr_any || ovr_addr == pend_addr)) begin
                    data   = ovr_data;
                    ovr_en = 1'b0;
                end
                MEM_RVALID = 1'b1;
                MEM_RDATA  = data;
                pend       = 1'b0;
                rsp_addr   = pend_addr;
                if (!stale) begin
                    e.pc    = pend_addr;
                    e.instr = data;
                    exp_q.push_back(e);
                    tb_fetch++;
                    if (data[15:12] == 4'hC) tb_br++;
                end
            end else if (pend) begin
                pend_stale = pend_stale | ~RESET_N;
            end

            if (MEM_REQ && gnt_en && !pend) begin
                MEM_GNT    = 1'b1;
                pend       = 1'b1;
                pend_addr  = MEM_ADDR;
                pend_stale = ~RESET_N;
            end

            if (MEM_RVALID && !force_rvalid) begin
                #1;
                rsp_branch = BRANCH;
                rsp_offset = OFFSET;
                rsp_cnt++;
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        repeat (cycles) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    // Find the next cycle with MEM_REQ high and step past its edge.
    task automatic expect_req_addr(input string name, input logic [15:0] exp);
        bit found;
        logic [15:0] a;
        found = 1'b0;
        a = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK); #2;
            if (MEM_REQ) begin
                a = MEM_ADDR;
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout(name);
        else begin
            check(name, 32'(a), 32'(exp));
            @(posedge CLK); #1;
        end
    endtask

    task automatic wait_ovr_used(input string name);
        for (int i = 0; i < 80; i++) begin
            @(posedge CLK);
            if (!ovr_en) break;
        end
        if (ovr_en) begin
            timeout(name);
            ovr_en = 1'b0;
        end
    endtask

    task automatic br_vec(input int idx, input br_vec_t v);
        logic [15:0] target;
        ovr_data = v.data;
        ovr_any  = 1'b1;
        ovr_en   = 1'b1;
        wait_ovr_used($sformatf("vec%0d_rsp", idx));
        check($sformatf("vec%0d_branch", idx), 32'(rsp_branch), 32'(v.exp_br));
        check($sformatf("vec%0d_offset", idx), 32'(rsp_offset), 32'(v.exp_off));
        target = rsp_addr + 16'(v.delta);
        expect_req_addr($sformatf("vec%0d_next_addr", idx), target);
    endtask

    br_vec_t tbl[8];
    int      pop_base;
    logic [15:0] stall_addr;

    initial begin
        tbl[0] = '{16'hC0FE, 1'b1, 8'hFE, -2};
        tbl[1] = '{16'hC005, 1'b1, 8'h05, 5};
        tbl[2] = '{16'hB0FE, 1'b0, 8'h00, 1};
        tbl[3] = '{16'hD0FE, 1'b0, 8'h00, 1};
        tbl[4] = '{16'hC080, 1'b1, 8'h80, -128};
        tbl[5] = '{16'hC07F, 1'b1, 8'h7F, 127};
        tbl[6] = '{16'hCF00, 1'b1, 8'h00, 0};
        tbl[7] = '{16'h0C12, 1'b0, 8'h00, 1};

        // T1: reset held with a spurious response on the bus.
        RESET_N      = 1'b0;
        INSTR_READY  = 1'b1;
        force_rvalid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("t1_pc", 32'(PC), 32'h0);
        check("t1_mem_req", 32'(MEM_REQ), 32'h0);
        check("t1_instr_valid", 32'(INSTR_VALID), 32'h0);
        check("t1_branch", 32'(BRANCH), 32'h0);
        check("t1_offset", 32'(OFFSET), 32'h0);
        force_rvalid = 1'b0;

        // T2: sequential fetch from reset, exact first-fetch timing.
        RESET_N  = 1'b1;
        pop_base = pop_cnt;
        @(posedge CLK); #1;
        check("t2_req", 32'(MEM_REQ), 32'h1);
        check("t2_addr", 32'(MEM_ADDR), 32'h0);
        @(posedge CLK); #1;
        check("t2_wait_req", 32'(MEM_REQ), 32'h0);
        check("t2_empty", 32'(INSTR_VALID), 32'h0);
        @(posedge CLK); #1;
        check("t2_first_valid", 32'(INSTR_VALID), 32'h1);
        check("t2_first_pc", 32'(INSTR_PC), 32'h0);
        check("t2_first_instr", 32'(INSTR), 32'h1000);
        check("t2_pc_adv", 32'(PC), 32'h1);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            if (pop_cnt - pop_base >= 4) break;
        end
        if (pop_cnt - pop_base < 4) timeout("t2_four_pops");

        // T3: branch back at PC 5.
        do_reset(1);
        ovr_addr = 16'h0005;
        ovr_data = 16'hC0FE;
        ovr_any  = 1'b0;
        ovr_en   = 1'b1;
        wait_ovr_used("t3_rsp");
        check("t3_rsp_addr", 32'(rsp_addr), 32'h5);
        check("t3_branch", 32'(rsp_branch), 32'h1);
        check("t3_offset", 32'(rsp_offset), 32'hFE);
        @(negedge CLK); #2;
        check("t3_branch_drop", 32'(BRANCH), 32'h0);
        check("t3_req", 32'(MEM_REQ), 32'h1);
        check("t3_target", 32'(MEM_ADDR), 32'h3);
        @(posedge CLK); #1;

        // Predecode table.
        for (int i = 0; i < 8; i++) br_vec(i, tbl[i]);

        // T4: backpressure fills the buffer, one pop restarts fetch at PC 4.
        INSTR_READY = 1'b0;
        do_reset(1);
        repeat (14) @(posedge CLK);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("t4_parked_req", 32'(MEM_REQ), 32'h0);
            check("t4_head_pc", 32'(INSTR_PC), 32'h0);
            check("t4_pc", 32'(PC), 32'h4);
        end
        INSTR_READY = 1'b1;
        @(posedge CLK); #1;
        INSTR_READY = 1'b0;
        check("t4_head_after_pop", 32'(INSTR_PC), 32'h1);
        expect_req_addr("t4_resume", 16'h0004);
        INSTR_READY = 1'b1;

        // Grant stall: request and address held until granted.
        gnt_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK); #2;
            if (MEM_REQ) break;
        end
        stall_addr = MEM_ADDR;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("stall_req", 32'(MEM_REQ), 32'h1);
            check("stall_addr", 32'(MEM_ADDR), 32'(stall_addr));
        end
        gnt_en = 1'b1;
        repeat (6) @(posedge CLK);

        // T5: branch from 0 by -2, then wrap through FFFF to 0000.
        do_reset(1);
        ovr_addr = 16'h0000;
        ovr_data = 16'hC0FE;
        ovr_any  = 1'b0;
        ovr_en   = 1'b1;
        expect_req_addr("t5_a0", 16'h0000);
        expect_req_addr("t5_fffe", 16'hFFFE);
        expect_req_addr("t5_ffff", 16'hFFFF);
        expect_req_addr("t5_0000", 16'h0000);

        // T6: reset while waiting; the late response must be ignored.
        INSTR_READY = 1'b0;
        hold_rsp    = 1'b1;
        do_reset(1);
        expect_req_addr("t6_pre_addr", 16'h0000);
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        RESET_N  = 1'b1;
        ovr_addr = 16'h0000;
        ovr_data = 16'hC0FE;
        ovr_any  = 1'b0;
        ovr_en   = 1'b1;
        hold_rsp = 1'b0;
        @(negedge CLK); #2;
        check("t6_stale_rvalid", 32'(MEM_RVALID), 32'h1);
        check("t6_stale_branch", 32'(BRANCH), 32'h0);
        check("t6_stale_req", 32'(MEM_REQ), 32'h0);
        @(posedge CLK); #1;
        check("t6_no_push", 32'(INSTR_VALID), 32'h0);
        check("t6_pc", 32'(PC), 32'h0);
        expect_req_addr("t6_first_addr", 16'h0000);
        repeat (3) @(posedge CLK);
        #1;
        check("t6_real_valid", 32'(INSTR_VALID), 32'h1);
        check("t6_real_instr", 32'(INSTR), 32'h1000);
        INSTR_READY = 1'b1;
        repeat (20) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
